fcs_deserializer: RTL and testbench
===================================

FCS_DESERIALIZER -- requirements
Module: fcs_deserializer

Interface
REQ-001 The block SHALL have parameter GEN_WIDTH, default 17, the generator polynomial width.
REQ-002 The block SHALL have parameter REM_WIDTH, default GEN_WIDTH-1, the FCS remainder width in bits.
REQ-003 CLK  input  1  system clock; all state SHALL change on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 Ser_In  input  1  serial FCS bit, LSB first.
REQ-006 Valid_In  input  1  high only in the cycle that carries bit 0 of a frame.
REQ-007 Rx_enable  input  1  high for the whole frame; low means the link is idle or aborted.
REQ-008 Expected_FCS  input  REM_WIDTH  locally computed FCS to compare against.
REQ-009 Rx_FCS  output  REM_WIDTH  last fully assembled remainder.
REQ-010 Rx_done  output  1  one-cycle pulse when a frame completes.
REQ-011 FCS_ok  output  1  assembled value equals Expected_FCS.
REQ-012 FCS_err  output  1  assembled value differs from Expected_FCS.
REQ-013 Busy  output  1  reception in progress.
REQ-014 Abort  output  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-015 The FSM SHALL have three states: IDLE, RECV and DONE; all outputs SHALL be registered.
REQ-016 Frame start SHALL be defined as Valid_In=1 AND Rx_enable=1 at an edge (edge 0).
- On frame start: the block SHALL sample Ser_In as bit 0, set bit count to 1, enter RECV and clear FCS_ok and FCS_err.
- Frame start is accepted in IDLE and in DONE.
REQ-017 In RECV, with Rx_enable=1 and Valid_In=0, each edge SHALL shift Ser_In in at the MSB: shreg <= {Ser_In, shreg[REM_WIDTH-1:1]}, and increment the count.
REQ-018 Bit k SHALL be sampled at edge k, for k = 0..REM_WIDTH-1.
REQ-019 On the edge that samples bit REM_WIDTH-1, the block SHALL:
- load Rx_FCS with the assembled word (bit 0 at Rx_FCS[0]);
- compare the assembled word with the Expected_FCS value present at that edge;
- set FCS_ok or FCS_err (exactly one) and pulse Rx_done;
- enter DONE.
REQ-020 Rx_done SHALL be high for exactly one cycle; DONE SHALL return to IDLE after one cycle unless a frame start occurs.
REQ-021 Rx_FCS, FCS_ok and FCS_err SHALL hold until the next frame start; Rx_FCS alone SHALL hold until the next completion.
REQ-022 Busy SHALL be 1 in RECV, and 0 in IDLE and DONE.
REQ-023 Rx_enable=0 in RECV SHALL:
- discard the partial word and clear the count;
- pulse Abort;
- enter IDLE;
- leave Rx_FCS unchanged and keep FCS_ok and FCS_err at 0.
REQ-024 Valid_In=1 in RECV (resync) SHALL:
- pulse Abort;
- treat the cycle as a new frame start, with Ser_In as bit 0 and count 1;
- stay in RECV.
REQ-025 Valid_In=1 with Rx_enable=0 SHALL be ignored in every state.
REQ-026 The bit counter SHALL be $clog2(REM_WIDTH)+1 bits wide and SHALL never exceed REM_WIDTH.
REQ-027 Back-to-back frames SHALL be supported: a frame start in the DONE cycle SHALL be accepted with no lost cycle.
REQ-028 Rx_FCS SHALL match the parallel value fed to the serializing transmitter, which sends bit 0 first with its valid flag.

Reset
REQ-029 RST=0 SHALL asynchronously force the following, regardless of state or mid-frame position:
- state to IDLE, count to 0, shreg to 0;
- Rx_FCS to 0;
- Rx_done, FCS_ok, FCS_err, Busy and Abort to 0.
REQ-030 After RST deasserts, the first frame start SHALL be accepted at the first rising edge that sees it.

Verification
REQ-031 REM_WIDTH=16: Valid_In at edge 0, serial 0xA5C3 LSB first, Expected_FCS=0xA5C3 -> at edge 15 Rx_done=1, Rx_FCS=0xA5C3, FCS_ok=1, FCS_err=0; Busy high for edges 0..14.
REQ-032 Same stream with Expected_FCS=0xA5C2 -> Rx_done=1, FCS_err=1, FCS_ok=0, Rx_FCS=0xA5C3.
REQ-033 Rx_enable dropped after 8 bits of 0x1234 -> Abort pulse, IDLE, no Rx_done; Rx_FCS keeps its previous value.
REQ-034 Valid_In re-asserted at bit 5, then a full 0xFFFF frame -> Abort pulse; 16 edges after resync Rx_FCS=0xFFFF and Rx_done=1.
REQ-035 Two frames 0x0001 then 0x8000, the second starting in the DONE cycle -> two Rx_done pulses exactly 16 cycles apart, with correct Rx_FCS each time.
REQ-036 RST pulsed low at bit 10 -> all outputs are 0 immediately; the next full frame 0x5A5A completes correctly.

Source files
------------

// File: rtl/fcs_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : fcs_deserializer
//  Description : Reassembles a serially received FCS (LSB first) into a
//                parallel remainder and compares it against a locally
//                computed FCS. A three-state FSM (IDLE / RECV / DONE) tracks
//                the frame. Every output is registered.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    GEN_WIDTH    generator polynomial width (default 17)
//    REM_WIDTH    FCS remainder width in bits (default GEN_WIDTH-1)
//  Ports
//    CLK          in   1          system clock, rising edge
//    RST          in   1          asynchronous reset, active low
//    Ser_In       in   1          serial FCS bit, LSB first
//    Valid_In     in   1          high only in the cycle carrying bit 0
//    Rx_enable    in   1          high for the whole frame; low = idle/abort
//    Expected_FCS in   REM_WIDTH  locally computed FCS
//    Rx_FCS       out  REM_WIDTH  last fully assembled remainder
//    Rx_done      out  1          one-cycle pulse on frame completion
//    FCS_ok       out  1          assembled value equals Expected_FCS
//    FCS_err      out  1          assembled value differs from Expected_FCS
//    Busy         out  1          reception in progress
//    Abort        out  1          one-cycle pulse when a partial frame is lost
// ============================================================================
module fcs_deserializer #(
    parameter int GEN_WIDTH = 17,
    parameter int REM_WIDTH = GEN_WIDTH - 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Ser_In,
    input  logic                 Valid_In,
    input  logic                 Rx_enable,
    input  logic [REM_WIDTH-1:0] Expected_FCS,
    output logic [REM_WIDTH-1:0] Rx_FCS,
    output logic                 Rx_done,
    output logic                 FCS_ok,
    output logic                 FCS_err,
    output logic                 Busy,
    output logic                 Abort
);

    localparam int CNT_WIDTH = $clog2(REM_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(REM_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [CNT_WIDTH-1:0]   cnt, cnt_n;
    logic [REM_WIDTH-1:0]   shreg, shreg_n;
    logic [REM_WIDTH-1:0]   rx_fcs_n;
    logic                   done_n, ok_n, err_n, abort_n;
    logic                   frame_start;

    // Bits enter at the MSB and walk down, so after REM_WIDTH samples bit 0
    // lands at index 0. Shifting a (REM_WIDTH+1)-bit concatenation keeps the
    // expression legal even for REM_WIDTH = 1.
    logic [REM_WIDTH:0]     shift_ext;
    logic [REM_WIDTH:0]     start_ext;
    logic [REM_WIDTH-1:0]   shift_word;
    logic [REM_WIDTH-1:0]   start_word;

    assign frame_start = Valid_In & Rx_enable;
    assign shift_ext   = {Ser_In, shreg} >> 1;
    assign start_ext   = {Ser_In, {REM_WIDTH{1'b0}}} >> 1;
    assign shift_word  = shift_ext[REM_WIDTH-1:0];
    assign start_word  = start_ext[REM_WIDTH-1:0];

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        rx_fcs_n = Rx_FCS;
        done_n   = 1'b0;
        ok_n     = FCS_ok;
        err_n    = FCS_err;
        abort_n  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (frame_start) begin
                    state_n = RECV;
                    cnt_n   = CNT_WIDTH'(1);
                    shreg_n = start_word;
                    ok_n    = 1'b0;
                    err_n   = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            RECV: begin
                if (!Rx_enable) begin
                    // Link dropped mid-frame: throw the partial word away.
                    state_n = IDLE;
                    cnt_n   = '0;
                    shreg_n = '0;
                    abort_n = 1'b1;
                end else if (Valid_In) begin
                    // Resync: a new bit 0 arrived before the old frame ended.
                    cnt_n   = CNT_WIDTH'(1);
                    shreg_n = start_word;
                    ok_n    = 1'b0;
                    err_n   = 1'b0;
                    abort_n = 1'b1;
                end else begin
                    cnt_n   = cnt + CNT_WIDTH'(1);
                    shreg_n = shift_word;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                shreg_n = '0;
            end
        endcase

        // Completion is detected on the edge that samples the last bit, so
        // the result is published without an extra cycle of latency.
        if (state_n == RECV && cnt_n == CNT_FULL) begin
            rx_fcs_n = shreg_n;
            ok_n     = (shreg_n == Expected_FCS);
            err_n    = (shreg_n != Expected_FCS);
            done_n   = 1'b1;
            state_n  = DONE;
            cnt_n    = '0;
            shreg_n  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            Rx_FCS  <= '0;
            Rx_done <= 1'b0;
            FCS_ok  <= 1'b0;
            FCS_err <= 1'b0;
            Busy    <= 1'b0;
            Abort   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            Rx_FCS  <= rx_fcs_n;
            Rx_done <= done_n;
            FCS_ok  <= ok_n;
            FCS_err <= err_n;
            Busy    <= (state_n == RECV);
            Abort   <= abort_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fcs_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fcs_deserializer
//  Description : Directed self-checking bench for fcs_deserializer with
//                REM_WIDTH = 16. Inputs change 1 ns after each rising edge
//                and outputs are sampled at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fcs_deserializer;

    logic        CLK;
    logic        RST;
    logic        Ser_In;
    logic        Valid_In;
    logic        Rx_enable;
    logic [15:0] Expected_FCS;
    logic [15:0] Rx_FCS;
    logic        Rx_done;
    logic        FCS_ok;
    logic        FCS_err;
    logic        Busy;
    logic        Abort;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int done_cyc = 0;
    int first_done = 0;

    fcs_deserializer #(
        .GEN_WIDTH(17),
        .REM_WIDTH(16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Ser_In       (Ser_In),
        .Valid_In     (Valid_In),
        .Rx_enable    (Rx_enable),
        .Expected_FCS (Expected_FCS),
        .Rx_FCS       (Rx_FCS),
        .Rx_done      (Rx_done),
        .FCS_ok       (FCS_ok),
        .FCS_err      (FCS_err),
        .Busy         (Busy),
        .Abort        (Abort)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic en);
        Ser_In    = s;
        Valid_In  = v;
        Rx_enable = en;
        tick();
    endtask

    // Full frame: 16 bits LSB first, Valid_In with bit 0 only.
    task automatic send_frame(input logic [15:0] word, input logic [15:0] exp_fcs,
                              input logic exp_ok, input logic exp_abort0);
        Expected_FCS = exp_fcs;
        for (int i = 0; i < 16; i++) begin
            drive(word[i], (i == 0), 1'b1);
            if (i == 0) check("abort_at_start", Abort, exp_abort0);
            if (i < 15) begin
                check("busy_in_frame", Busy, 1);
                check("done_early", Rx_done, 0);
            end
        end
        done_cyc = cyc;
        check("rx_done", Rx_done, 1);
        check("rx_fcs", Rx_FCS, word);
        check("fcs_ok", FCS_ok, exp_ok);
        check("fcs_err", FCS_err, !exp_ok);
        check("busy_after_done", Busy, 0);
        Valid_In = 1'b0;
    endtask

    // Partial frame of n bits, no completion expected.
    task automatic send_bits(input logic [15:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            drive(word[i], (i == 0), 1'b1);
        end
    endtask

    initial begin
        RST          = 1'b0;
        Ser_In       = 1'b0;
        Valid_In     = 1'b0;
        Rx_enable    = 1'b0;
        Expected_FCS = 16'h0000;

        // Reset state
        #12;
        check("rst_rx_fcs", Rx_FCS, 16'h0000);
        check("rst_done", Rx_done, 0);
        check("rst_ok", FCS_ok, 0);
        check("rst_err", FCS_err, 0);
        check("rst_busy", Busy, 0);
        check("rst_abort", Abort, 0);
        RST = 1'b1;

        // Valid_In without Rx_enable is ignored
        drive(1'b1, 1'b1, 1'b0);
        check("ign_busy", Busy, 0);
        check("ign_abort", Abort, 0);

        // Matching FCS
        send_frame(16'hA5C3, 16'hA5C3, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("done_one_cycle", Rx_done, 0);
        check("hold_rx_fcs", Rx_FCS, 16'hA5C3);
        check("hold_ok", FCS_ok, 1);
        check("idle_busy", Busy, 0);

        // Mismatching FCS
        send_frame(16'hA5C3, 16'hA5C2, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Abort after 8 bits of 0x1234
        send_bits(16'h1234, 8);
        check("pre_abort_busy", Busy, 1);
        drive(1'b0, 1'b0, 1'b0);
        check("abort_pulse", Abort, 1);
        check("abort_busy", Busy, 0);
        check("abort_no_done", Rx_done, 0);
        check("abort_keep_fcs", Rx_FCS, 16'hA5C3);
        check("abort_ok", FCS_ok, 0);
        check("abort_err", FCS_err, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("abort_one_cycle", Abort, 0);

        // Resync at bit 5, then a full 0xFFFF frame
        send_bits(16'h0000, 5);
        send_frame(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);

        // Back-to-back frames, second starts in the DONE cycle
        send_frame(16'h0001, 16'h0001, 1'b1, 1'b0);
        first_done = done_cyc;
        send_frame(16'h8000, 16'h8000, 1'b1, 1'b0);
        check("b2b_spacing", done_cyc - first_done, 16);
        drive(1'b0, 1'b0, 1'b0);
        check("b2b_done_low", Rx_done, 0);

        // Reset mid-frame at bit 10
        send_bits(16'h5A5A, 10);
        RST = 1'b0;
        #1;
        check("mid_rst_rx_fcs", Rx_FCS, 16'h0000);
        check("mid_rst_done", Rx_done, 0);
        check("mid_rst_ok", FCS_ok, 0);
        check("mid_rst_err", FCS_err, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_abort", Abort, 0);
        #1;
        RST = 1'b1;
        send_frame(16'h5A5A, 16'h5A5A, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
